// File: rtl/serial_slt_if.sv
// rtl/serial_slt_if.sv - control/bit-stream/result bundle for serial_slt
//   start, bit_valid, a_bit, b_bit : master -> slave (command and LSB-first operand bits)
//   ready, busy, done              : slave -> master (FSM status, done is a 1-cycle pulse)
//   out, eq, c_out                 : slave -> master (a<b, a==b, carry of a+~b+1; held)
interface serial_slt_if;
  logic start;
  logic bit_valid;
  logic a_bit;
  logic b_bit;
  logic ready;
  logic busy;
  logic done;
  logic out;
  logic eq;
  logic c_out;

  modport master (
    output start, bit_valid, a_bit, b_bit,
    input  ready, busy, done, out, eq, c_out
  );

  modport slave (
    input  start, bit_valid, a_bit, b_bit,
    output ready, busy, done, out, eq, c_out
  );
endinterface

// File: rtl/serial_slt.sv
// rtl/serial_slt.sv - bit-serial signed less-than / equality comparator
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : serial_slt_if.slave (start/bit stream in, status and held results out)
// Computes a + ~b + 1 one bit per accepted cycle, LSB first; the sign bit
// (counter == N-1) resolves overflow and registers out/eq/c_out.
module serial_slt #(
  parameter int N = 32
) (
  input logic         clk,
  input logic         rst,
  serial_slt_if.slave bus
);

  localparam int CW = $clog2(N) + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          carry;
  logic          zero;
  logic          out_q;
  logic          eq_q;
  logic          c_out_q;

  logic          nb;
  logic          sum;
  logic          carry_next;
  logic          last_bit;

  // One full-adder slice of a + ~b with the running carry.
  always_comb begin
    nb         = ~bus.b_bit;
    sum        = bus.a_bit ^ nb ^ carry;
    carry_next = (bus.a_bit & nb) | (bus.a_bit & carry) | (nb & carry);
    last_bit   = (cnt == CW'(N - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      carry   <= 1'b1;
      zero    <= 1'b1;
      out_q   <= 1'b0;
      eq_q    <= 1'b0;
      c_out_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            state <= S_SHIFT;
            cnt   <= '0;
            carry <= 1'b1;
            zero  <= 1'b1;
          end
        end
        S_SHIFT: begin
          if (bus.bit_valid) begin
            carry <= carry_next;
            cnt   <= cnt + CW'(1);
            if (sum) begin
              zero <= 1'b0;
            end
            if (last_bit) begin
              // Signed overflow is carry-in XOR carry-out of the sign slice;
              // flipping the sum sign by it gives the true sign of a - b.
              out_q   <= sum ^ (carry ^ carry_next);
              eq_q    <= zero & ~sum;
              c_out_q <= carry_next;
              state   <= S_DONE;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.ready = (state == S_IDLE);
  assign bus.busy  = (state == S_SHIFT);
  assign bus.done  = (state == S_DONE);
  assign bus.out   = out_q;
  assign bus.eq    = eq_q;
  assign bus.c_out = c_out_q;

endmodule

// File: tb/tb_serial_slt.sv
// tb/tb_serial_slt.sv - directed and exhaustive checks for serial_slt (N=8 and N=4)
module tb_serial_slt;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  serial_slt_if i8 ();
  serial_slt_if i4 ();

  serial_slt #(.N(8)) dut8 (.clk(clk), .rst(rst), .bus(i8.slave));
  serial_slt #(.N(4)) dut4 (.clk(clk), .rst(rst), .bus(i4.slave));

  int vectors     = 0;
  int miscompares = 0;
  int d8 = 0;
  int d4 = 0;

  always @(posedge clk) begin
    if (i8.done === 1'b1) d8++;
    if (i4.done === 1'b1) d4++;
  end

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    bit         stall;
    bit         poke;
    logic [2:0] exp;   // {out, eq, c_out}
    int         lat;   // cycles from start cycle to done cycle, inclusive
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic cmp8(input vec_t v);
    int idx;
    int cyc;
    int d0;
    logic [2:0] snap;
    bit moved;
    @(posedge clk); #1;
    snap  = {i8.out, i8.eq, i8.c_out};
    moved = 1'b0;
    d0    = d8;
    i8.start     = 1'b1;
    i8.bit_valid = 1'b0;
    @(posedge clk); #1;
    chk($sformatf("accept a=%0h b=%0h", v.a, v.b), {31'd0, i8.busy}, 32'd1);
    i8.start = 1'b0;
    idx = 0;
    cyc = 0;
    while (idx < 8 && cyc < 100) begin
      i8.start = v.poke;
      if (v.stall && (cyc % 2 == 1)) begin
        // Garbage bits on stall cycles must not be absorbed.
        i8.bit_valid = 1'b0;
        i8.a_bit     = ~v.a[idx];
        i8.b_bit     = ~v.b[idx];
      end else begin
        i8.bit_valid = 1'b1;
        i8.a_bit     = v.a[idx];
        i8.b_bit     = v.b[idx];
        idx++;
      end
      @(posedge clk); #1;
      cyc++;
      if (i8.busy === 1'b1 && {i8.out, i8.eq, i8.c_out} !== snap) moved = 1'b1;
    end
    i8.start     = 1'b0;
    i8.bit_valid = 1'b0;
    while (i8.done !== 1'b1 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk($sformatf("hold a=%0h b=%0h", v.a, v.b), {31'd0, moved}, 32'd0);
    chk($sformatf("latency a=%0h b=%0h", v.a, v.b), cyc + 1, v.lat);
    chk($sformatf("result a=%0h b=%0h", v.a, v.b), {29'd0, i8.out, i8.eq, i8.c_out}, {29'd0, v.exp});
    @(posedge clk); #1;
    chk($sformatf("done_pulse a=%0h b=%0h", v.a, v.b), {29'd0, i8.done, i8.ready, i8.busy}, 32'b010);
    chk($sformatf("done_count a=%0h b=%0h", v.a, v.b), d8 - d0, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] fa;
    logic [7:0] fb;
    logic [3:0] a4;
    logic [3:0] b4;
    logic [2:0] e4;
    int d0;

    //              a      b      stall poke  {out,eq,c} lat
    tbl[0] = '{8'd3,   8'd5,   1'b0, 1'b0, 3'b100, 9};
    tbl[1] = '{8'h80,  8'h01,  1'b0, 1'b0, 3'b101, 9};
    tbl[2] = '{8'h7F,  8'hFF,  1'b0, 1'b0, 3'b000, 9};
    tbl[3] = '{8'hF9,  8'hF9,  1'b0, 1'b0, 3'b011, 9};
    tbl[4] = '{8'd5,   8'd3,   1'b1, 1'b1, 3'b001, 16};
    tbl[5] = '{8'h00,  8'h00,  1'b0, 1'b1, 3'b011, 9};
    tbl[6] = '{8'h80,  8'h7F,  1'b0, 1'b0, 3'b101, 9};
    tbl[7] = '{8'h7F,  8'h80,  1'b1, 1'b0, 3'b000, 16};
    tbl[8] = '{8'hFF,  8'h00,  1'b0, 1'b0, 3'b101, 9};

    i8.start = 1'b0; i8.bit_valid = 1'b0; i8.a_bit = 1'b0; i8.b_bit = 1'b0;
    i4.start = 1'b0; i4.bit_valid = 1'b0; i4.a_bit = 1'b0; i4.b_bit = 1'b0;

    #2 rst = 1'b1;
    #1;
    chk("reset_state8", {26'd0, i8.ready, i8.busy, i8.done, i8.out, i8.eq, i8.c_out}, 32'b100000);
    chk("reset_state4", {26'd0, i4.ready, i4.busy, i4.done, i4.out, i4.eq, i4.c_out}, 32'b100000);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      cmp8(tbl[i]);
    end

    // Abort after 4 bits with an asynchronous reset.
    fa = 8'h55; fb = 8'h33;
    @(posedge clk); #1;
    d0 = d8;
    i8.start = 1'b1;
    @(posedge clk); #1;
    i8.start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      i8.bit_valid = 1'b1; i8.a_bit = fa[k]; i8.b_bit = fb[k];
      @(posedge clk); #1;
    end
    chk("mid_shift_busy", {31'd0, i8.busy}, 32'd1);
    i8.bit_valid = 1'b0;
    rst = 1'b1;
    #2;
    chk("rst_async", {26'd0, i8.ready, i8.busy, i8.done, i8.out, i8.eq, i8.c_out}, 32'b100000);
    @(posedge clk); @(posedge clk); #1;
    // First edge after release must accept start.
    rst = 1'b0;
    i8.start = 1'b1;
    @(posedge clk); #1;
    chk("start_after_rst", {31'd0, i8.busy}, 32'd1);
    chk("abort_no_done", d8 - d0, 0);
    i8.start = 1'b0;
    fa = 8'hFE; fb = 8'h00;
    for (int k = 0; k < 8; k++) begin
      i8.bit_valid = 1'b1; i8.a_bit = fa[k]; i8.b_bit = fb[k];
      @(posedge clk); #1;
    end
    i8.bit_valid = 1'b0;
    chk("fresh_m2_vs_0", {28'd0, i8.done, i8.out, i8.eq, i8.c_out}, 32'b1101);
    @(posedge clk); #1;

    // Exhaustive N=4, back-to-back with start held through DONE and IDLE.
    d0 = d4;
    i4.start = 1'b1;
    for (int p = 0; p < 256; p++) begin
      a4 = p[7:4];
      b4 = p[3:0];
      e4 = {($signed(a4) < $signed(b4)), (a4 == b4), (a4 >= b4)};
      @(posedge clk); #1;
      i4.start = 1'b0;
      for (int k = 0; k < 4; k++) begin
        i4.bit_valid = 1'b1; i4.a_bit = a4[k]; i4.b_bit = b4[k];
        @(posedge clk); #1;
      end
      i4.bit_valid = 1'b0;
      chk($sformatf("x4 a=%0h b=%0h", a4, b4), {28'd0, i4.done, i4.out, i4.eq, i4.c_out}, {28'd0, 1'b1, e4});
      i4.start = 1'b1;
      @(posedge clk); #1;
      chk($sformatf("x4_idle a=%0h b=%0h", a4, b4), {30'd0, i4.ready, i4.busy}, 32'b10);
    end
    i4.start = 1'b0;
    @(posedge clk); #1;
    chk("x4_done_count", d4 - d0, 256);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
